// File: rtl/nibble_deser_pkg.sv
// Shared defaults, FSM state encoding and width helpers for the nibble deserializer.
package nibble_deser_pkg;

  localparam int unsigned DefWidth = 4;
  localparam int unsigned DefDepth = 4;

  typedef logic [0:0] state_t;

  localparam state_t StIdle    = 1'b0;
  localparam state_t StCollect = 1'b1;

  localparam int unsigned DefCountW = $clog2(DefDepth + 1);

  function automatic int unsigned count_width(int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/nibble_deserializer_fifo.sv
// Synchronous FIFO with occupancy count; a push while full is taken only alongside a pop.
module sync_fifo
  import nibble_deser_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               data_i,
  input  logic                           pop_i,
  output logic [WIDTH-1:0]               data_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [count_width(DEPTH)-1:0]  count_o
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CountW = count_width(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0] count_q, count_d;
  logic              wr_en, rd_en;

  assign full_o  = (count_q == CountW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rd_en   = pop_i && !empty_o;
  assign wr_en   = push_i && (!full_o || rd_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (wr_en && !rd_en) begin
      count_d = count_q + CountW'(1);
    end else if (rd_en && !wr_en) begin
      count_d = count_q - CountW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (wr_en) mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/nibble_deserializer.sv
// MSB-first serial-to-parallel receiver feeding a small FIFO with a valid/ready output.
module nibble_deserializer
  import nibble_deser_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         serial_in,
  input  logic                         bit_valid,
  input  logic                         flush,
  output logic [WIDTH-1:0]             dout,
  output logic                         dout_valid,
  input  logic                         dout_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         busy
);

  localparam int unsigned CntW = $clog2(WIDTH);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              overflow_q, overflow_d;
  logic [WIDTH-1:0]  word;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;

  assign word = {acc_q[WIDTH-2:0], serial_in};
  assign pop  = dout_valid && dout_ready;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    overflow_d = overflow_q;
    push       = 1'b0;
    if (flush) begin
      // Flush wins over a coincident bit; that bit is lost.
      acc_d      = '0;
      cnt_d      = '0;
      state_d    = StIdle;
      overflow_d = 1'b0;
    end else if (bit_valid) begin
      acc_d = word;
      if (cnt_q == CntW'(WIDTH - 1)) begin
        push    = 1'b1;
        cnt_d   = '0;
        state_d = StIdle;
        if (fifo_full && !pop) overflow_d = 1'b1;
      end else begin
        cnt_d   = cnt_q + CntW'(1);
        state_d = StCollect;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .data_i  (word),
    .pop_i   (pop),
    .data_o  (dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count)
  );

  assign dout_valid = !fifo_empty;
  assign busy       = (state_q == StCollect);
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_nibble_deserializer.sv
// Scoreboard bench: bit-list reference model predicts words, monitor checks on each handshake.
module tb_nibble_deserializer;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             serial_in = 1'b0;
  logic             bit_valid = 1'b0;
  logic             flush = 1'b0;
  logic             dout_ready = 1'b0;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic [2:0]       count;
  logic             overflow;
  logic             busy;

  nibble_deserializer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .serial_in  (serial_in),
    .bit_valid  (bit_valid),
    .flush      (flush),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .count      (count),
    .overflow   (overflow),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit run = 1'b0;

  // Reference model state
  int unsigned sb[$];
  bit          bitq[$];
  int          occ = 0;
  bit          ovf = 1'b0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    sb.delete();
    bitq.delete();
    occ = 0;
    ovf = 1'b0;
  endtask

  // One clock: inputs held from now until the next edge, then the model absorbs that edge.
  task automatic cyc(input bit bv, input bit b, input bit fl, input bit rdy);
    bit          pop;
    int unsigned w;
    bit_valid  = bv;
    serial_in  = b;
    flush      = fl;
    dout_ready = rdy;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_clear();
    end else begin
      pop = rdy && (occ > 0);
      if (fl) begin
        bitq.delete();
        ovf = 1'b0;
      end else if (bv) begin
        bitq.push_back(b);
        if (bitq.size() == WIDTH) begin
          w = 0;
          foreach (bitq[i]) w = w * 2 + int'(bitq[i]);
          bitq.delete();
          if (occ < DEPTH || pop) begin
            sb.push_back(w);
            occ++;
          end else begin
            ovf = 1'b1;
          end
        end
      end
      if (pop) occ--;
    end
  endtask

  task automatic send_word(input int unsigned w, input bit rdy);
    for (int i = WIDTH - 1; i >= 0; i--) cyc(1'b1, w[i], 1'b0, rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, rdy);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_dout"}, dout, 0);
    chk({tag, "_dout_valid"}, dout_valid, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_overflow"}, overflow, 0);
  endtask

  // Monitor: compares status every cycle and pops the scoreboard on each accepted word.
  initial begin
    forever begin
      @(negedge clk);
      if (run) begin
        chk("dout_valid", dout_valid, (occ > 0) ? 1 : 0);
        chk("count", count, occ);
        chk("busy", busy, (bitq.size() > 0) ? 1 : 0);
        chk("overflow", overflow, ovf);
        if (dout_valid && dout_ready) begin
          chk("sb_nonempty", (sb.size() != 0) ? 1 : 0, 1);
          if (sb.size() != 0) chk("dout", dout, sb.pop_front());
        end
      end
    end
  end

  initial begin
    #1;
    check_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run   = 1'b1;

    // 1,0,1,1 -> B
    send_word(4'hB, 1'b1);
    idle(3, 1'b1);

    // Overflow on the fifth word, then drain
    send_word(4'hA, 1'b0);
    send_word(4'h5, 1'b0);
    send_word(4'hF, 1'b0);
    send_word(4'h0, 1'b0);
    send_word(4'h3, 1'b0);
    idle(1, 1'b0);
    chk("ovf_set", overflow, 1);
    idle(6, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);

    // Full FIFO, last bit of fifth word coincides with a pop
    send_word(4'hA, 1'b0);
    send_word(4'h5, 1'b0);
    send_word(4'hF, 1'b0);
    send_word(4'h0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    idle(1, 1'b0);
    chk("no_ovf", overflow, 0);
    chk("still_full", count, 4);
    idle(6, 1'b1);

    // Partial word flushed, then 6
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    send_word(4'h6, 1'b1);
    idle(3, 1'b1);

    // Flush beats a coincident bit
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    send_word(4'hC, 1'b1);
    idle(3, 1'b1);

    // Reset mid-word with two words buffered
    send_word(4'h7, 1'b0);
    send_word(4'hE, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    run   = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run   = 1'b1;
    send_word(4'h9, 1'b1);
    idle(3, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 60) == 0),
          ($urandom_range(0, 2) == 0));
    end
    idle(8, 1'b1);
    chk("drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
